// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus between fetch_sequencer, InstructionMemory and the datapath.
// Retired_cnt exists only when FETCH_PERF_CNT_EN is defined.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] Address;
  logic              I_rd;
  logic [15:0]       Instruction;
  logic [15:0]       IR;
  logic              Dec_valid;
  logic              Exec_done;
  logic              Zero;
  logic [ADDR_W-1:0] PC;
  logic              Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       Retired_cnt;

  modport master (
    output Address, I_rd, IR, Dec_valid, PC, Halted, Retired_cnt,
    input  Instruction, Exec_done, Zero
  );
  modport slave (
    input  Address, I_rd, IR, Dec_valid, PC, Halted, Retired_cnt,
    output Instruction, Exec_done, Zero
  );
`else
  modport master (
    output Address, I_rd, IR, Dec_valid, PC, Halted,
    input  Instruction, Exec_done, Zero
  );
  modport slave (
    input  Address, I_rd, IR, Dec_valid, PC, Halted,
    output Instruction, Exec_done, Zero
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// PC/fetch controller: FETCH -> DECODE -> EXEC, jz redirect, sticky halt.
// Optional retired-instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_DEPTH = 128,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic               Clk,
  input  logic               Rst,
  fetch_sequencer_if.master  bus
);

  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_oob;
  logic              w_illegal;
  logic              w_take;

  assign w_oob     = ({1'b0, r_pc} >= DEPTH_L);
  assign w_illegal = (r_ir[15:12] > 4'd5);
  assign w_take    = (r_ir[15:12] == 4'd5) && bus.Zero;
  assign w_offset  = {{(ADDR_W-8){r_ir[7]}}, r_ir[7:0]};
  assign w_pc_next = r_pc + (w_take ? w_offset : ADDR_W'(1));

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = w_oob ? S_HALT : S_DECODE;
      S_DECODE: w_next = w_illegal ? S_HALT : S_EXEC;
      S_EXEC:   w_next = bus.Exec_done ? S_FETCH : S_EXEC;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while Rst is high, whatever state reset interrupted.
  // An illegal opcode never raises Dec_valid, so the datapath never starts it.
  always_comb begin
    bus.I_rd      = 1'b0;
    bus.Dec_valid = 1'b0;
    bus.Halted    = 1'b0;
    if (!Rst) begin
      bus.I_rd      = (r_state == S_FETCH) && !w_oob;
      bus.Dec_valid = (r_state == S_DECODE) && !w_illegal;
      bus.Halted    = (r_state == S_HALT);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc <= RESET_PC_L;
      r_ir <= '0;
    end else begin
      if (r_state == S_FETCH && !w_oob) r_ir <= bus.Instruction;
      if (r_state == S_EXEC && bus.Exec_done) r_pc <= w_pc_next;
    end
  end

  assign bus.Address = r_pc;
  assign bus.PC      = r_pc;
  assign bus.IR      = r_ir;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_retired;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_retired <= '0;
    end else if (r_state == S_EXEC && bus.Exec_done && r_retired != '1) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign bus.Retired_cnt = r_retired;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random programs
// checked against an instruction-level model of PC/IR/halt behaviour.
module tb_fetch_sequencer;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  fetch_sequencer_if #(.ADDR_W(16)) bus ();

  fetch_sequencer #(
    .ADDR_W   (16),
    .MEM_DEPTH(128),
    .RESET_PC (0)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  logic [15:0] mem [0:127];
  always_comb bus.Instruction = (bus.Address < 16'd128) ? mem[bus.Address[6:0]] : 16'h0000;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  int unsigned m_retired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
    chk(tag, bus.Retired_cnt, m_retired);
`else
    if (tag.len() == 0) $display("unused tag");
`endif
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 128; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.Exec_done = 1'b0;
    bus.Zero = 1'b0;
    #1;
    chk("rst_ird", bus.I_rd, 0);
    chk("rst_decv", bus.Dec_valid, 0);
    chk("rst_halted", bus.Halted, 0);
    cyc();
    cyc();
    chk("rst_pc", bus.PC, 0);
    chk("rst_ir", bus.IR, 0);
    Rst = 1'b0;
    #1;
    m_pc = 16'h0000;
    m_ir = 16'h0000;
    m_retired = 0;
    chk("rst_first_ird", bus.I_rd, 1);
    chk("rst_first_addr", bus.Address, 0);
    chk("rst_first_halted", bus.Halted, 0);
    chk_cnt("rst_cnt");
  endtask

  // One instruction from its FETCH cycle; h=1 when the model expects a halt.
  task automatic do_instr(input int unsigned waits, input logic z, output bit h);
    logic [15:0] inst;
    logic [3:0]  op;
    h = 1'b0;
    chk("fetch_addr", bus.Address, m_pc);
    chk("fetch_pc", bus.PC, m_pc);
    chk("fetch_halted", bus.Halted, 0);
    if (m_pc >= 16'd128) begin
      chk("oob_ird", bus.I_rd, 0);
      bus.Exec_done = 1'($urandom);
      cyc();
      chk("oob_halted", bus.Halted, 1);
      chk("oob_ird_halt", bus.I_rd, 0);
      chk("oob_pc", bus.PC, m_pc);
      h = 1'b1;
      return;
    end
    inst = mem[m_pc[6:0]];
    op   = inst[15:12];
    chk("fetch_ird", bus.I_rd, 1);
    chk("fetch_decv", bus.Dec_valid, 0);
    bus.Exec_done = 1'($urandom);
    cyc();
    m_ir = inst;
    chk("dec_ir", bus.IR, inst);
    chk("dec_pc", bus.PC, m_pc);
    chk("dec_ird", bus.I_rd, 0);
    chk("dec_valid", bus.Dec_valid, (op <= 4'd5));
    bus.Exec_done = 1'($urandom);
    cyc();
    if (op > 4'd5) begin
      chk("ill_halted", bus.Halted, 1);
      chk("ill_decv", bus.Dec_valid, 0);
      chk("ill_ird", bus.I_rd, 0);
      h = 1'b1;
      return;
    end
    for (int unsigned i = 0; i < waits; i++) begin
      bus.Exec_done = 1'b0;
      chk("exec_wait_ird", bus.I_rd, 0);
      chk("exec_wait_ir", bus.IR, inst);
      chk("exec_wait_pc", bus.PC, m_pc);
      cyc();
    end
    chk("exec_decv", bus.Dec_valid, 0);
    chk("exec_ird", bus.I_rd, 0);
    chk("exec_ir", bus.IR, inst);
    bus.Exec_done = 1'b1;
    bus.Zero = z;
    cyc();
    bus.Exec_done = 1'b0;
    if (op == 4'd5 && z) m_pc = 16'(int'(m_pc) + int'($signed(inst[7:0])));
    else                 m_pc = 16'(int'(m_pc) + 1);
    if (m_retired < 65535) m_retired++;
    chk_cnt("retired_cnt");
  endtask

  task automatic halt_hold(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.Exec_done = 1'($urandom);
      bus.Zero = 1'($urandom);
      cyc();
      chk("halt_halted", bus.Halted, 1);
      chk("halt_ird", bus.I_rd, 0);
      chk("halt_decv", bus.Dec_valid, 0);
      chk("halt_pc", bus.PC, m_pc);
      chk("halt_ir", bus.IR, m_ir);
    end
    bus.Exec_done = 1'b0;
    chk_cnt("halt_cnt");
  endtask

  initial begin
    bit h;
    Rst = 1'b1;
    bus.Exec_done = 1'b0;
    bus.Zero = 1'b0;
    fill_mem(16'h2000);
    cyc();
    do_reset();

    // Directed path: lwc, adds, jz forward/backward, self-loop, long wait, illegal.
    mem[0]  = 16'h301E;
    mem[8]  = 16'h5000;
    mem[9]  = 16'h5602;
    mem[12] = 16'h56FC;
    mem[13] = 16'h7000;
    do_instr(0, 1'b0, h);
    for (int i = 1; i < 8; i++) do_instr(0, 1'b0, h);
    do_instr(1, 1'b0, h);
    do_instr(0, 1'b1, h);
    do_instr(0, 1'b0, h);
    do_instr(2, 1'b1, h);
    do_instr(0, 1'b1, h);
    do_instr(0, 1'b0, h);
    do_instr(0, 1'b0, h);
    do_instr(5, 1'b1, h);
    do_instr(0, 1'b0, h);
    do_instr(0, 1'b0, h);
    do_instr(0, 1'b0, h);
    chk("illegal_halt_flag", 32'(h), 1);
    halt_hold(4);
    do_reset();

    // Jump to the last valid word, then fall off the end of memory.
    fill_mem(16'h2000);
    mem[0] = 16'h507F;
    do_instr(0, 1'b1, h);
    do_instr(0, 1'b0, h);
    do_instr(0, 1'b0, h);
    chk("oob_halt_flag", 32'(h), 1);
    halt_hold(3);
    do_reset();

    // Negative offset from PC 0 wraps to 16'hFF80, which then halts.
    mem[0] = 16'h5080;
    do_instr(0, 1'b1, h);
    do_instr(0, 1'b0, h);
    chk("wrap_halt_flag", 32'(h), 1);
    do_reset();

    // Reset while waiting in EXEC after some retirements.
    mem[0] = 16'h2000;
    for (int i = 0; i < 4; i++) do_instr(0, 1'b0, h);
    bus.Exec_done = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("midexec_ird", bus.I_rd, 0);
    do_reset();

    // Random programs, mostly legal opcodes with occasional illegal ones.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 128; i++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
        mem[i] = {op, 12'($urandom)};
      end
      do_reset();
      h = 1'b0;
      for (int k = 0; k < 40 && !h; k++) do_instr($urandom_range(0, 3), 1'($urandom), h);
      if (h) halt_hold(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
